oversample_bit_counter: RTL and testbench

OVERSAMPLE_BIT_COUNTER -- requirements
Module: oversample_bit_counter

---
 rtl/oversample_bit_counter_if.sv | 31 +++
 rtl/oversample_bit_counter.sv | 121 ++++++++++++
 tb/tb_oversample_bit_counter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/oversample_bit_counter_if.sv
// Oversampling bit-counter bus: the receiver FSM (master) requests
// counting and supplies the frame configuration; the counter (slave)
// returns edge/bit positions and the majority-vote sample points.
interface oversample_bit_counter_if #(
  parameter int PRESCALE_W = 7,
  parameter int BIT_CNT_W  = 4
);
  logic                  clear;
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  edge_count_done;
  logic                  sample_strobe;
  logic [1:0]            sample_idx;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  frame_done;
  logic                  cfg_error;

  modport master (
    output clear, enable, prescale, frame_bits,
    input  edge_count, edge_count_done, sample_strobe, sample_idx,
           bit_count, frame_done, cfg_error
  );

  modport slave (
    input  clear, enable, prescale, frame_bits,
    output edge_count, edge_count_done, sample_strobe, sample_idx,
           bit_count, frame_done, cfg_error
  );
endinterface

// File: rtl/oversample_bit_counter.sv
// Oversampling bit counter for a UART-style receiver. Counts clk edges
// within each bit period (prescale clocks per bit) and bits within a
// frame, and flags the three centre samples used for majority voting.
// Configuration is latched at the start of a frame so the receiver may
// change it freely while a frame is in flight.
module oversample_bit_counter #(
  parameter int PRESCALE_W = 7,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  oversample_bit_counter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]            r_state;
  logic [PRESCALE_W-1:0] r_edge_count;
  logic [BIT_CNT_W-1:0]  r_bit_count;
  logic [PRESCALE_W-1:0] r_prescale_q;
  logic [BIT_CNT_W-1:0]  r_frame_bits_q;

  logic                  w_cfg_legal;
  logic                  w_counting;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_sample0;
  logic                  w_edge_done;
  logic                  w_frame_done;
  logic                  w_strobe;
  logic [1:0]            w_idx;

  // An odd or too-small ratio has no centred 3-sample window; a zero
  // bit count has no frame at all.
  assign w_cfg_legal = (bus.prescale >= PRESCALE_W'(4)) &&
                       !bus.prescale[0] &&
                       (bus.frame_bits != '0);

  assign w_counting   = (r_state == S_COUNT);
  assign w_half       = r_prescale_q >> 1;
  assign w_sample0    = w_half - PRESCALE_W'(2);
  assign w_edge_done  = w_counting && (r_edge_count == r_prescale_q - PRESCALE_W'(1));
  assign w_frame_done = w_edge_done && (r_bit_count == r_frame_bits_q - BIT_CNT_W'(1));

  // Decode the three sample points h-2, h-1, h around the bit centre.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the if-chain can leave it unassigned (latch).
    w_strobe = 1'b0;
    w_idx    = 2'd0;
    if (w_counting) begin
      if (r_edge_count == w_sample0) begin
        w_strobe = 1'b1;
        w_idx    = 2'd0;
      end else if (r_edge_count == w_sample0 + PRESCALE_W'(1)) begin
        w_strobe = 1'b1;
        w_idx    = 2'd1;
      end else if (r_edge_count == w_half) begin
        w_strobe = 1'b1;
        w_idx    = 2'd2;
      end
    end
  end

  // State, counters and latched configuration.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      r_state        <= S_IDLE;
      r_edge_count   <= '0;
      r_bit_count    <= '0;
      r_prescale_q   <= '0;
      r_frame_bits_q <= '0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_edge_count <= '0;
      r_bit_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_edge_count <= '0;
          r_bit_count  <= '0;
          if (bus.enable && w_cfg_legal) begin
            r_state        <= S_COUNT;
            r_prescale_q   <= bus.prescale;
            r_frame_bits_q <= bus.frame_bits;
          end
        end
        S_COUNT: begin
          if (!bus.enable || w_frame_done) begin
            r_state      <= S_IDLE;
            r_edge_count <= '0;
            r_bit_count  <= '0;
          end else if (w_edge_done) begin
            r_edge_count <= '0;
            r_bit_count  <= r_bit_count + BIT_CNT_W'(1);
          end else begin
            r_edge_count <= r_edge_count + PRESCALE_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_edge_count <= '0;
          r_bit_count  <= '0;
        end
      endcase
    end
  end

  assign bus.edge_count      = r_edge_count;
  assign bus.bit_count       = r_bit_count;
  assign bus.edge_count_done = w_edge_done;
  assign bus.frame_done      = w_frame_done;
  assign bus.sample_strobe   = w_strobe;
  assign bus.sample_idx      = w_idx;
  // Only output with an input path: reports the config the receiver is
  // offering while the counter is waiting to start.
  assign bus.cfg_error       = !w_counting && !w_cfg_legal;

endmodule

// File: tb/tb_oversample_bit_counter.sv
// Directed bench for oversample_bit_counter: normal frames at several
// ratios, illegal configurations, mid-frame config changes, clear and
// enable aborts, and asynchronous reset mid-frame.
module tb_oversample_bit_counter;

  localparam int PW = 7;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  oversample_bit_counter_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  oversample_bit_counter #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // All counters and decodes zero, block in IDLE.
  task automatic check_idle(input string tag, input logic exp_cfg_err);
    check({tag, " state"},      32'(dut.r_state), 32'd0);
    check({tag, " edge_count"}, 32'(bus.edge_count), 32'd0);
    check({tag, " bit_count"},  32'(bus.bit_count), 32'd0);
    check({tag, " edge_done"},  32'(bus.edge_count_done), 32'd0);
    check({tag, " strobe"},     32'(bus.sample_strobe), 32'd0);
    check({tag, " idx"},        32'(bus.sample_idx), 32'd0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, " cfg_error"},  32'(bus.cfg_error), 32'(exp_cfg_err));
  endtask

  // Runs one frame from an IDLE start. s0 is the hand-computed first
  // sample point (prescale/2 - 2). stop_kind: 0 full frame, 1 clear,
  // 2 enable drop, 3 async reset, applied after COUNT cycle stop_cyc.
  // At COUNT cycle chg_cyc the prescale input is changed to chg_ps.
  task automatic run_frame(input string tag, input int ps, input int fb, input int s0,
                           input int stop_cyc, input int stop_kind,
                           input int chg_cyc, input int chg_ps);
    int total;
    int last;
    int pulses;
    int e_edge;
    int e_bit;
    logic e_strobe;
    total  = ps * fb;
    last   = (stop_cyc >= 0) ? stop_cyc : total - 1;
    pulses = 0;
    @(negedge clk);
    bus.prescale   = PW'(ps);
    bus.frame_bits = BW'(fb);
    bus.clear      = 1'b0;
    bus.enable     = 1'b1;
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      e_edge   = cyc % ps;
      e_bit    = cyc / ps;
      e_strobe = (e_edge >= s0) && (e_edge <= s0 + 2);
      check({tag, " edge_count"}, 32'(bus.edge_count), 32'(e_edge));
      check({tag, " bit_count"},  32'(bus.bit_count), 32'(e_bit));
      check({tag, " edge_done"},  32'(bus.edge_count_done), 32'(e_edge == ps - 1));
      check({tag, " strobe"},     32'(bus.sample_strobe), 32'(e_strobe));
      check({tag, " idx"},        32'(bus.sample_idx), e_strobe ? 32'(e_edge - s0) : 32'd0);
      check({tag, " frame_done"}, 32'(bus.frame_done), 32'(cyc == total - 1));
      check({tag, " cfg_error"},  32'(bus.cfg_error), 32'd0);
      if (bus.edge_count_done) pulses++;
      if (cyc == chg_cyc) bus.prescale = PW'(chg_ps);
    end
    case (stop_kind)
      0: begin
        // enable still high: the return to IDLE must come from frame_done
        @(negedge clk);
        check_idle({tag, " end"}, 1'b0);
        bus.enable = 1'b0;
        check({tag, " pulses"}, 32'(pulses), 32'(fb));
      end
      1: begin
        bus.clear = 1'b1;
        @(negedge clk);
        check_idle({tag, " clr"}, 1'b0);
        // clear still wins over a legal start request while idle
        @(negedge clk);
        check_idle({tag, " clr_hold"}, 1'b0);
        bus.clear  = 1'b0;
        bus.enable = 1'b0;
      end
      2: begin
        bus.enable = 1'b0;
        @(negedge clk);
        check_idle({tag, " en0"}, 1'b0);
      end
      default: begin
        #2 reset = 1'b0;
        #1;
        check_idle({tag, " rst_async"}, 1'b0);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check_idle({tag, " post_rst"}, 1'b0);
        end
      end
    endcase
  endtask

  task automatic check_illegal(input string tag, input int ps, input int fb);
    @(negedge clk);
    bus.prescale   = PW'(ps);
    bus.frame_bits = BW'(fb);
    bus.enable     = 1'b1;
    #1 check({tag, " cfg_error_comb"}, 32'(bus.cfg_error), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(tag, 1'b1);
    end
    bus.enable = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    bus.clear      = 1'b0;
    bus.enable     = 1'b0;
    bus.prescale   = '0;
    bus.frame_bits = '0;
    #12;
    // in reset with an illegal (all-zero) config offered
    check_idle("reset", 1'b1);
    bus.prescale   = PW'(8);
    bus.frame_bits = BW'(10);
    #1 check("reset cfg_legal", 32'(bus.cfg_error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("idle", 1'b0);

    run_frame("norm8x10",  8,  10, 2,  -1, 0, -1, 0);
    run_frame("ratio12x3", 12, 3,  4,  -1, 0, -1, 0);
    run_frame("min4x2",    4,  2,  0,  -1, 0, -1, 0);
    run_frame("fb1",       6,  1,  1,  -1, 0, -1, 0);
    run_frame("max126x2",  126, 2, 61, -1, 0, -1, 0);
    run_frame("full15",    8,  15, 2,  -1, 0, -1, 0);

    check_illegal("ill_ps7", 7, 10);
    check_illegal("ill_ps2", 2, 10);
    check_illegal("ill_fb0", 8, 0);

    run_frame("chg16to8",  16, 4,  6,  -1, 0, 32, 8);

    run_frame("abort_clr",  8, 10, 2, 37, 1, -1, 0);
    run_frame("restart1",   8, 10, 2, -1, 0, -1, 0);
    run_frame("abort_en0",  8, 10, 2, 37, 2, -1, 0);
    run_frame("en0_at_done", 8, 10, 2, 39, 2, -1, 0);
    run_frame("restart2",   8, 10, 2, -1, 0, -1, 0);
    run_frame("abort_rst",  8, 10, 2, 20, 3, -1, 0);
    run_frame("restart3",   8, 10, 2, -1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
